// File: rtl/board_move_collector_pkg.sv
// Shared definitions for the board-level move collection stage and the column units.
package board_move_collector_pkg;

  localparam int unsigned MOVE_W = 48;
  localparam int unsigned NCOL   = 8;
  localparam int unsigned FLD_W  = 6;
  localparam int unsigned NFLD   = MOVE_W / FLD_W;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned PTR_W  = $clog2(NCOL);

  typedef logic [MOVE_W-1:0] move_t;

  typedef enum logic [2:0] {
    IDLE,
    WAITCOL,
    ISSUE,
    CAPTURE,
    FLUSH
  } state_t;

  // A self-to-self move: every field repeats the lowest field.
  function automatic logic is_end_marker(input move_t w);
    logic m;
    m = 1'b1;
    for (int unsigned f = 1; f < NFLD; f++) begin
      if (w[f*FLD_W +: FLD_W] != w[FLD_W-1:0]) m = 1'b0;
    end
    return m;
  endfunction

endpackage

// File: rtl/board_move_collector_out_reg.sv
// Single-entry valid/ready output register; can_load_c says a new word may enter next edge.
module move_out_reg
  import board_move_collector_pkg::*;
(
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  move_t load_data,
  input  logic  m_ready,
  output logic  m_valid,
  output move_t m_data,
  output logic  can_load_c
);

  assign can_load_c = !m_valid || m_ready;

  // Load wins over drain so a reload in the accept cycle keeps m_valid high.
  always_ff @(posedge clk) begin
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= '0;
    end else if (load) begin
      m_valid <= 1'b1;
      m_data  <= load_data;
    end else if (m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/board_move_collector.sv
// Drains the eight column FIFOs in order into one move stream and counts delivered moves.
module board_move_collector
  import board_move_collector_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [NCOL-1:0]         col_done,
  output logic [NCOL-1:0]         col_rden,
  input  logic [NCOL*MOVE_W-1:0]  col_rdata,
  output logic                    m_valid,
  output logic [MOVE_W-1:0]       m_data,
  input  logic                    m_ready,
  output logic                    busy,
  output logic                    all_done,
  output logic [CNT_W-1:0]        move_count,
  output logic                    cnt_sat
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t            state_q, state_d;
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              busy_d, all_done_d, cnt_sat_d;
  logic [CNT_W-1:0]  count_d;
  logic              can_load, load, transfer;
  move_t             col_word [NCOL];
  move_t             rd_word;

  for (genvar i = 0; i < NCOL; i++) begin : g_unpack
    assign col_word[i] = col_rdata[i*MOVE_W +: MOVE_W];
  end

  assign rd_word  = col_word[ptr_q];
  assign transfer = m_valid && m_ready;

  move_out_reg u_out (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .load_data  (rd_word),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .can_load_c (can_load)
  );

  // Next state, read strobe and counters.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    busy_d     = busy;
    all_done_d = all_done;
    count_d    = move_count;
    cnt_sat_d  = cnt_sat;
    col_rden   = '0;
    load       = 1'b0;

    if (transfer && (move_count != CNT_MAX)) begin
      count_d = move_count + CNT_W'(1);
      if (count_d == CNT_MAX) cnt_sat_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          count_d    = '0;
          cnt_sat_d  = 1'b0;
          all_done_d = 1'b0;
          ptr_d      = '0;
          busy_d     = 1'b1;
          state_d    = WAITCOL;
        end
      end
      WAITCOL: begin
        if (col_done[ptr_q]) state_d = ISSUE;
      end
      ISSUE: begin
        // Only read when the word can be stored next cycle; one read in flight at most.
        if (can_load) begin
          col_rden = NCOL'(1) << ptr_q;
          state_d  = CAPTURE;
        end
      end
      CAPTURE: begin
        if (is_end_marker(rd_word)) begin
          if (ptr_q == PTR_W'(NCOL-1)) begin
            state_d = FLUSH;
          end else begin
            ptr_d   = ptr_q + PTR_W'(1);
            state_d = WAITCOL;
          end
        end else begin
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      FLUSH: begin
        if (!m_valid) begin
          all_done_d = 1'b1;
          busy_d     = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      busy       <= 1'b0;
      all_done   <= 1'b0;
      move_count <= '0;
      cnt_sat    <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      busy       <= busy_d;
      all_done   <= all_done_d;
      move_count <= count_d;
      cnt_sat    <= cnt_sat_d;
    end
  end

endmodule

// File: doc/board_move_collector.md
Name: board_move_collector

Overview:
- Board-level stage directly downstream of the eight column units.
- Waits on each column's done flag, then drains that column's 48-bit move FIFO in column order 0..7. Each column's list ends with a self-to-self end marker.
- Forwards every non-marker word to one valid/ready move stream and counts the moves.
- Raises all_done once all columns have delivered their end markers; the search controller then reads the full move list for the current board.

Parameters:
MOVE_W, 48, width of one column FIFO word
NCOL, 8, number of column units
FLD_W, 6, width of one {x,y} field inside a move word; MOVE_W/FLD_W fields per word
CNT_W, 8, width of move_count

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a collection pass
col_done  in  NCOL  per-column done level (column unit in DONE state)
col_rden  out  NCOL  one-hot read enable to the column FIFOs
col_rdata  in  NCOL*MOVE_W  column FIFO outputs; column i at [i*MOVE_W +: MOVE_W]
m_valid  out  1  output move valid
m_data  out  MOVE_W  output move word
m_ready  in  1  downstream accept
busy  out  1  pass in progress
all_done  out  1  level; every column drained and output register empty
move_count  out  CNT_W  number of moves accepted by downstream in this pass, saturating
cnt_sat  out  1  sticky; move_count saturated during this pass

Behaviour:
- Reset: state IDLE, col_rden=0, m_valid=0, m_data=0, busy=0, all_done=0, move_count=0, cnt_sat=0, column pointer=0. A reset mid-pass aborts the pass immediately and discards any in-flight read data.
- End marker: a word whose MOVE_W/FLD_W fields are all equal to field [FLD_W-1:0]. The marker is never forwarded and is never counted.
- Read latency: the selected column's col_rdata is valid exactly 1 cycle after its col_rden pulse.
- At most one read is in flight at any time. This prevents reading past the marker. Peak throughput is 1 word every 2 cycles.
- State machine:
  - IDLE: on start, clear move_count, cnt_sat and all_done, set ptr=0, set busy=1, go to WAITCOL. While IDLE, all_done holds its last value.
  - WAITCOL: when col_done[ptr]=1, go to ISSUE. Columns are served strictly in order, never out of order, even if a later column finishes first.
  - ISSUE: pulse col_rden[ptr] for 1 cycle, but only if the output register is empty or is being accepted this cycle (m_valid & m_ready). Then go to CAPTURE; otherwise stay in ISSUE.
  - CAPTURE: sample col_rdata[ptr].
    - Marker: if ptr==NCOL-1 go to FLUSH, else ptr+1 and go to WAITCOL.
    - Otherwise: load m_data, set m_valid=1, go to ISSUE.
  - FLUSH: wait until m_valid=0, then set all_done=1, busy=0, go to IDLE.
- Output handshake:
  - m_data and m_valid are held stable while m_valid & !m_ready.
  - A transfer occurs on m_valid & m_ready; m_valid drops the next cycle unless CAPTURE reloads it in the same cycle.
- Counting: move_count increments on each transfer. At 2^CNT_W-1 it holds and sets cnt_sat.
- start while busy=1 is ignored.
- col_done dropping after its column has been drained is ignored.
- A column that is not yet done stalls the pass indefinitely; there is no timeout.

Decomposition:
- Shared chess package holds MOVE_W, FLD_W, NCOL, the state encoding (IDLE/WAITCOL/ISSUE/CAPTURE/FLUSH) and an is_end_marker function. The column unit reuses the same function.
- One natural sub-module, move_out_reg: a single-entry valid/ready output register with a "can load" output. It keeps the handshake logic separate from the FSM.

Test Plan:
- Reset, start, all col_done=1, each column returns 2 moves then a marker, m_ready=1 -> 16 words out in order col0..col7, move_count=16, all_done=1, busy=0.
- Column 3 returns only a marker (empty column) -> no words from col3, col_rden[3] pulses exactly once, pass completes.
- col_done[5] held low for 50 cycles while the others are high -> no col_rden[6] or col_rden[7] until col_done[5] rises; output order unchanged.
- m_ready toggles 1,0,0,1 during a transfer -> m_data/m_valid stable while stalled, no lost or duplicated words, col_rden not issued while the register is full and not draining.
- 300 moves from a single column with CNT_W=8 -> move_count=255, cnt_sat=1, all 300 words delivered.
- reset asserted mid-CAPTURE of column 2 -> next cycle m_valid=0, col_rden=0, busy=0, move_count=0; a new start restarts from column 0.
